// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - RGB duty sequencer: manual pass-through or keyframe fades
module rgb_fade_sequencer #(
    parameter int WIDTH    = 8,
    parameter int NUM_KEYS = 4,
    parameter int RATE_W   = 16,
    localparam int IW      = $clog2(NUM_KEYS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [3*WIDTH-1:0]   cfg_wdata,
    input  logic                 pwm_sync,
    input  logic [WIDTH-1:0]     man_r,
    input  logic [WIDTH-1:0]     man_g,
    input  logic [WIDTH-1:0]     man_b,
    output logic [WIDTH-1:0]     duty_r,
    output logic [WIDTH-1:0]     duty_g,
    output logic [WIDTH-1:0]     duty_b,
    output logic                 busy,
    output logic [IW-1:0]        key_idx,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Channel 2 is red (MSBs of a key word), channel 0 is blue.
    logic [3*WIDTH-1:0]        key_q [NUM_KEYS];
    logic [RATE_W-1:0]         rate_q;
    logic [7:0]                hold_q;
    logic                      run_q;
    logic                      loop_q;
    logic [IW-1:0]             last_q;

    state_e                    state_q, state_d;
    logic [IW-1:0]             key_idx_q, key_idx_d;
    logic [2:0][WIDTH-1:0]     lvl_q, lvl_d;
    logic [2:0][WIDTH-1:0]     duty_q;
    logic [RATE_W-1:0]         presc_q, presc_d;
    logic [7:0]                hold_cnt_q, hold_cnt_d;
    logic                      done_q, done_d;
    logic                      seq_end;

    logic                      wr_key, wr_rate, wr_hold, wr_ctrl;
    logic [2:0]                last_raw;
    logic [IW-1:0]             last_wr;
    logic [3*WIDTH-1:0]        key_tgt;
    logic [RATE_W-1:0]         rate_eff;
    logic [7:0]                hold_eff;
    logic                      run_eff;
    logic                      loop_eff;
    logic [IW-1:0]             last_eff;
    logic                      tick;

    // Register decode; a write in the same cycle overrides the stored value so
    // the FSM and prescaler always act on the freshest configuration.
    always_comb begin
        wr_key   = cfg_we && (cfg_addr < 4'(NUM_KEYS));
        wr_rate  = cfg_we && (cfg_addr == 4'd8);
        wr_hold  = cfg_we && (cfg_addr == 4'd9);
        wr_ctrl  = cfg_we && (cfg_addr == 4'd10);
        last_raw = cfg_wdata[4:2];
        if (last_raw > 3'(NUM_KEYS - 1)) begin
            last_wr = IW'(NUM_KEYS - 1);
        end else begin
            last_wr = last_raw[IW-1:0];
        end
        if (wr_key && (cfg_addr[IW-1:0] == key_idx_q)) begin
            key_tgt = cfg_wdata;
        end else begin
            key_tgt = key_q[key_idx_q];
        end
        rate_eff = wr_rate ? cfg_wdata[RATE_W-1:0] : rate_q;
        hold_eff = wr_hold ? cfg_wdata[7:0] : hold_q;
        run_eff  = wr_ctrl ? cfg_wdata[0] : run_q;
        loop_eff = wr_ctrl ? cfg_wdata[1] : loop_q;
        last_eff = wr_ctrl ? last_wr : last_q;
        tick     = pwm_sync && (state_q != S_IDLE) && (presc_q == rate_eff);
    end

    // Configuration registers; a naturally finished sequence clears RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= '0;
            end
            rate_q <= '0;
            hold_q <= '0;
            run_q  <= 1'b0;
            loop_q <= 1'b0;
            last_q <= '0;
        end else begin
            if (wr_key) begin
                key_q[cfg_addr[IW-1:0]] <= cfg_wdata;
            end
            if (wr_rate) begin
                rate_q <= cfg_wdata[RATE_W-1:0];
            end
            if (wr_hold) begin
                hold_q <= cfg_wdata[7:0];
            end
            if (wr_ctrl) begin
                run_q  <= cfg_wdata[0];
                loop_q <= cfg_wdata[1];
                last_q <= last_wr;
            end
            if (seq_end) begin
                run_q <= 1'b0;
            end
        end
    end

    // Sequencer next-state: prescaler, ramp stepping, hold countdown, advance.
    always_comb begin
        state_d    = state_q;
        key_idx_d  = key_idx_q;
        lvl_d      = lvl_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        seq_end    = 1'b0;
        presc_d    = presc_q;

        if (state_q == S_IDLE) begin
            presc_d = '0;
        end else if (pwm_sync) begin
            presc_d = tick ? '0 : presc_q + RATE_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (run_eff) begin
                    state_d   = S_RAMP;
                    key_idx_d = '0;
                    lvl_d     = duty_q;
                end
            end
            S_RAMP: begin
                if (!run_eff) begin
                    state_d = S_IDLE;
                end else if (lvl_q == key_tgt) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = hold_eff;
                end else if (tick) begin
                    for (int c = 0; c < 3; c++) begin
                        if (lvl_q[c] < key_tgt[c*WIDTH +: WIDTH]) begin
                            lvl_d[c] = lvl_q[c] + WIDTH'(1);
                        end else if (lvl_q[c] > key_tgt[c*WIDTH +: WIDTH]) begin
                            lvl_d[c] = lvl_q[c] - WIDTH'(1);
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!run_eff) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (hold_cnt_q != 8'd0) begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end else if (key_idx_q < last_eff) begin
                        key_idx_d = key_idx_q + IW'(1);
                        state_d   = S_RAMP;
                    end else if (loop_eff) begin
                        key_idx_d = '0;
                        state_d   = S_RAMP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        seq_end = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            key_idx_q  <= '0;
            lvl_q      <= '0;
            presc_q    <= '0;
            hold_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_idx_q  <= key_idx_d;
            lvl_q      <= lvl_d;
            presc_q    <= presc_d;
            hold_cnt_q <= hold_cnt_d;
            done_q     <= done_d;
        end
    end

    // Duty latch: only moves on a PWM period wrap, using pre-update levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q <= '0;
        end else if (pwm_sync) begin
            duty_q <= (state_q == S_IDLE) ? {man_r, man_g, man_b} : lvl_q;
        end
    end

    assign duty_r  = duty_q[2];
    assign duty_g  = duty_q[1];
    assign duty_b  = duty_q[0];
    assign busy    = (state_q != S_IDLE);
    assign key_idx = key_idx_q;
    assign done    = done_q;

endmodule
